// File: rtl/csi_rx_ctrl_pkg.sv
// rtl/csi_rx_ctrl_pkg.sv - shared state type, default constants and helpers for the CSI RX link controller
package csi_rx_ctrl_pkg;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ARM     = 2'd1,
      S_RUN     = 2'd2,
      S_RECOVER = 2'd3
   } ctrl_state_t;

   localparam int TIMEOUT_CYCLES_DEF = 16384;
   localparam int ERR_LIMIT_DEF      = 4;
   localparam int RST_CYCLES_DEF     = 8;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/csi_rx_link_stats.sv
// rtl/csi_rx_link_stats.sv - frame/line edge detection and frame, line and ECC error counters
module csi_rx_link_stats
   import csi_rx_ctrl_pkg::*;
(
   input  logic        i_clock,
   input  logic        i_reset,
   input  logic        i_run,
   input  logic        i_recover,
   input  logic        i_in_frame,
   input  logic        i_in_line,
   input  logic        i_ecc_err,
   output logic [15:0] o_frame_count,
   output logic [15:0] o_lines_last_frame,
   output logic [15:0] o_ecc_err_count
);

   logic        r_frame_q;
   logic        r_line_q;
   logic [15:0] r_frame_count;
   logic [15:0] r_line_cnt;
   logic [15:0] r_lines_last;
   logic [15:0] r_ecc_cnt;
   logic        w_frame_rise;
   logic        w_frame_fall;
   logic        w_line_rise;

   assign w_frame_rise = i_run && i_in_frame && !r_frame_q;
   assign w_frame_fall = i_run && !i_in_frame && r_frame_q;
   assign w_line_rise  = i_run && i_in_line && !r_line_q;

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_frame_q     <= 1'b0;
         r_line_q      <= 1'b0;
         r_frame_count <= '0;
         r_line_cnt    <= '0;
         r_lines_last  <= '0;
         r_ecc_cnt     <= '0;
      end else begin
         // Flags are tracked outside RUN too, so re-entering RUN with a flag already high is not an edge
         r_frame_q <= i_recover ? 1'b0 : i_in_frame;
         r_line_q  <= i_recover ? 1'b0 : i_in_line;
         if (w_frame_rise) begin
            r_frame_count <= r_frame_count + 16'd1;
            r_line_cnt    <= '0;
         end else if (w_line_rise) begin
            r_line_cnt <= sat_inc16(r_line_cnt);
         end
         if (w_frame_fall) r_lines_last <= r_line_cnt;
         if (i_ecc_err)    r_ecc_cnt    <= sat_inc16(r_ecc_cnt);
      end
   end

   assign o_frame_count      = r_frame_count;
   assign o_lines_last_frame = r_lines_last;
   assign o_ecc_err_count    = r_ecc_cnt;

endmodule

// File: rtl/csi_rx_link_ctrl.sv
// rtl/csi_rx_link_ctrl.sv - CSI-2 RX handler sequencing FSM with stuck-packet watchdog and ECC supervisor
module csi_rx_link_ctrl
   import csi_rx_ctrl_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
   parameter int ERR_LIMIT      = ERR_LIMIT_DEF,
   parameter int RST_CYCLES     = RST_CYCLES_DEF
)(
   input  logic        i_clock,
   input  logic        i_reset,
   input  logic        i_cfg_enable,
   input  logic        i_link_ready,
   input  logic        i_hdl_sync_wait,
   input  logic        i_hdl_sync_seq,
   input  logic        i_hdl_ecc_ok,
   input  logic        i_hdl_in_frame,
   input  logic        i_hdl_in_line,
   output logic        o_hdl_enable,
   output logic        o_hdl_reset,
   output logic [1:0]  o_state_out,
   output logic [15:0] o_frame_count,
   output logic [15:0] o_lines_last_frame,
   output logic [15:0] o_ecc_err_count,
   output logic [7:0]  o_recover_count,
   output logic        o_sticky_timeout,
   output logic        o_sticky_ecc
);

   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam int EC_W = $clog2(ERR_LIMIT + 1);
   localparam int RC_W = $clog2(RST_CYCLES + 1);

   ctrl_state_t     r_state;
   logic [WD_W-1:0] r_wd_cnt;
   logic [EC_W-1:0] r_consec;
   logic [RC_W-1:0] r_rst_cnt;
   logic            r_hdl_enable;
   logic            r_hdl_reset;
   logic [7:0]      r_recover_count;
   logic            r_sticky_timeout;
   logic            r_sticky_ecc;
   logic            w_run;
   logic            w_wd_inc;
   logic            w_wd_fault;
   logic            w_ecc_bad;
   logic            w_ecc_fault;

   assign w_run       = (r_state == S_RUN);
   assign w_wd_inc    = w_run && !i_hdl_sync_wait;
   assign w_wd_fault  = w_wd_inc && (r_wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
   assign w_ecc_bad   = w_run && i_hdl_sync_seq && !i_hdl_ecc_ok;
   assign w_ecc_fault = w_ecc_bad && (r_consec >= EC_W'(ERR_LIMIT - 1));

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state          <= S_IDLE;
         r_hdl_enable     <= 1'b0;
         r_hdl_reset      <= 1'b1;
         r_wd_cnt         <= '0;
         r_consec         <= '0;
         r_rst_cnt        <= '0;
         r_recover_count  <= '0;
         r_sticky_timeout <= 1'b0;
         r_sticky_ecc     <= 1'b0;
      end else begin
         r_hdl_enable <= w_run;
         r_hdl_reset  <= (r_state == S_IDLE) || (r_state == S_RECOVER);
         r_wd_cnt     <= w_wd_inc ? r_wd_cnt + WD_W'(1) : '0;
         if (w_ecc_bad) begin
            if (r_consec != EC_W'(ERR_LIMIT)) r_consec <= r_consec + EC_W'(1);
         end else if (w_run && i_hdl_sync_seq) begin
            r_consec <= '0;
         end
         case (r_state)
            S_IDLE: if (i_cfg_enable) r_state <= S_ARM;
            S_ARM: begin
               if (!i_cfg_enable)     r_state <= S_IDLE;
               else if (i_link_ready) r_state <= S_RUN;
            end
            S_RUN: begin
               if (!i_cfg_enable) begin
                  r_state <= S_IDLE;
               end else if (!i_link_ready || w_wd_fault || w_ecc_fault) begin
                  r_state   <= S_RECOVER;
                  r_rst_cnt <= '0;
                  r_consec  <= '0;
                  if (r_recover_count != 8'hFF) r_recover_count <= r_recover_count + 8'd1;
                  // A lost link takes precedence, so faults are only recorded while the link is up
                  if (i_link_ready && w_wd_fault)  r_sticky_timeout <= 1'b1;
                  if (i_link_ready && w_ecc_fault) r_sticky_ecc     <= 1'b1;
               end
            end
            S_RECOVER: begin
               if (r_rst_cnt == RC_W'(RST_CYCLES - 1)) r_state <= i_cfg_enable ? S_ARM : S_IDLE;
               else r_rst_cnt <= r_rst_cnt + RC_W'(1);
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   csi_rx_link_stats u_stats (
      .i_clock            (i_clock),
      .i_reset            (i_reset),
      .i_run              (w_run),
      .i_recover          (r_state == S_RECOVER),
      .i_in_frame         (i_hdl_in_frame),
      .i_in_line          (i_hdl_in_line),
      .i_ecc_err          (w_ecc_bad),
      .o_frame_count      (o_frame_count),
      .o_lines_last_frame (o_lines_last_frame),
      .o_ecc_err_count    (o_ecc_err_count)
   );

   assign o_hdl_enable     = r_hdl_enable;
   assign o_hdl_reset      = r_hdl_reset;
   assign o_state_out      = r_state;
   assign o_recover_count  = r_recover_count;
   assign o_sticky_timeout = r_sticky_timeout;
   assign o_sticky_ecc     = r_sticky_ecc;

endmodule
